// File: rtl/miriscv_int_pkg.sv
// Shared types and constants for the miriscv interrupt controller.
package miriscv_int_pkg;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SERVE  = 2'd1,
        FINISH = 2'd2
    } int_state_e;

    localparam int MCAUSE_INT_BIT  = 31;
    localparam int INT_NUM_DEFAULT = 32;

endpackage

// File: rtl/miriscv_int_ctrl.sv
// Interrupt controller: masks level requests with mie, picks one by rotating scan,
// pulses int_o with mcause, and returns a one-hot int_fin_o once the core is done.
module miriscv_int_ctrl
    import miriscv_int_pkg::*;
#(
    parameter int INT_NUM = INT_NUM_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [INT_NUM-1:0] int_req_i,
    input  logic [INT_NUM-1:0] mie_i,
    input  logic               int_rst_i,
    output logic               int_o,
    output logic [31:0]        mcause_o,
    output logic [INT_NUM-1:0] int_fin_o
);

    localparam int CW = $clog2(INT_NUM);
    localparam logic [INT_NUM-1:0] FIN_BASE = {{(INT_NUM-1){1'b0}}, 1'b1};

    // Interrupt flag plus the line index in the low five bits.
    function automatic logic [31:0] mcause_of(input logic [CW-1:0] idx);
        logic [31:0] m;
        m                 = 32'h0000_0000;
        m[MCAUSE_INT_BIT] = 1'b1;
        m[4:0]            = 5'(idx);
        return m;
    endfunction

    int_state_e         r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_int, w_int_nxt;
    logic [31:0]        r_mcause, w_mcause_nxt;
    logic [INT_NUM-1:0] r_fin, w_fin_nxt;
    logic               w_hit;

    assign w_hit = int_req_i[r_cnt] & mie_i[r_cnt];

    // Next-state and next-output logic of the scan/serve/finish machine.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_int_nxt    = 1'b0;
        w_mcause_nxt = r_mcause;
        w_fin_nxt    = {INT_NUM{1'b0}};
        case (r_state)
            SCAN: begin
                if (w_hit) begin
                    w_state_nxt  = SERVE;
                    w_int_nxt    = 1'b1;
                    w_mcause_nxt = mcause_of(r_cnt);
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            SERVE: begin
                // Service completes only on mret; request or mask changes are ignored here.
                if (int_rst_i) begin
                    w_state_nxt = FINISH;
                    w_fin_nxt   = FIN_BASE << r_cnt;
                end else begin
                    w_state_nxt = SERVE;
                end
            end
            FINISH: begin
                w_state_nxt  = SCAN;
                w_cnt_nxt    = r_cnt + CW'(1);
                w_mcause_nxt = 32'h0000_0000;
            end
            default: begin
                w_state_nxt  = SCAN;
                w_cnt_nxt    = {CW{1'b0}};
                w_mcause_nxt = 32'h0000_0000;
            end
        endcase
    end

    // State, scan counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= SCAN;
            r_cnt    <= {CW{1'b0}};
            r_int    <= 1'b0;
            r_mcause <= 32'h0000_0000;
            r_fin    <= {INT_NUM{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_int    <= w_int_nxt;
            r_mcause <= w_mcause_nxt;
            r_fin    <= w_fin_nxt;
        end
    end

    assign int_o     = r_int;
    assign mcause_o  = r_mcause;
    assign int_fin_o = r_fin;

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// Directed self-checking bench for miriscv_int_ctrl.
module tb_miriscv_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] mie;
    logic        int_rst;
    logic        int_o;
    logic [31:0] mcause;
    logic [31:0] fin;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    miriscv_int_ctrl #(.INT_NUM(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .int_req_i (req),
        .mie_i     (mie),
        .int_rst_i (int_rst),
        .int_o     (int_o),
        .mcause_o  (mcause),
        .int_fin_o (fin)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given request/mask applied, released 1 time unit after an edge.
    task automatic do_reset(input logic [31:0] r, input logic [31:0] m);
        rst_n   = 1'b0;
        req     = r;
        mie     = m;
        int_rst = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_int(input int max, output logic found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (int_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic bad_int, bad_mc, bad_fin;
        bad_int = 1'b0; bad_mc = 1'b0; bad_fin = 1'b0;
        rst_n = 1'b0; req = 32'hFFFF_FFFF; mie = 32'hFFFF_FFFF; int_rst = 1'b0;
        #2;
        for (int i = 0; i < 6; i++) begin
            if (int_o !== 1'b0) bad_int = 1'b1;
            if (mcause !== 32'h0) bad_mc = 1'b1;
            if (fin !== 32'h0) bad_fin = 1'b1;
            tick();
        end
        n_total++; if (bad_int) $display("FAIL reset_int_o: got pulse, expected 0"); else n_pass++;
        n_total++; if (bad_mc) $display("FAIL reset_mcause: got %h expected 0", mcause); else n_pass++;
        n_total++; if (bad_fin) $display("FAIL reset_fin: got %h expected 0", fin); else n_pass++;
        // Release with line 0 active: first edge samples cnt 0, so int_o rises right away.
        req = 32'h0000_0001; mie = 32'h0000_0001;
        rst_n = 1'b1;
        tick();
        n_total++; if (int_o !== 1'b1) $display("FAIL reset_first_scan: int_o got %b expected 1", int_o); else n_pass++;
        n_total++; if (mcause !== 32'h8000_0000) $display("FAIL reset_first_mcause: got %h expected 80000000", mcause); else n_pass++;
    endtask

    task automatic test_basic_service();
        logic early;
        early = 1'b0;
        do_reset(32'h0008_0000, 32'h0008_0000);
        for (int k = 1; k < 20; k++) begin
            tick();
            if (int_o !== 1'b0) early = 1'b1;
        end
        n_total++; if (early) $display("FAIL basic_early: int_o seen before cycle 20, expected 0"); else n_pass++;
        tick();
        n_total++; if (int_o !== 1'b1) $display("FAIL basic_int_o: got %b expected 1 at cycle 20", int_o); else n_pass++;
        n_total++; if (mcause !== 32'h8000_0013) $display("FAIL basic_mcause: got %h expected 80000013", mcause); else n_pass++;
        tick();
        n_total++; if (int_o !== 1'b0) $display("FAIL basic_one_pulse: int_o got %b expected 0", int_o); else n_pass++;
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;
        req = 32'h0;
        n_total++; if (fin !== 32'h0008_0000) $display("FAIL basic_fin: got %h expected 00080000", fin); else n_pass++;
        n_total++; if (mcause !== 32'h8000_0013) $display("FAIL basic_mcause_finish: got %h expected 80000013", mcause); else n_pass++;
        tick();
        n_total++; if (fin !== 32'h0) $display("FAIL basic_fin_one_cycle: got %h expected 0", fin); else n_pass++;
        n_total++; if (mcause !== 32'h0) $display("FAIL basic_mcause_clear: got %h expected 0", mcause); else n_pass++;
    endtask

    task automatic test_masking();
        logic seen_int, seen_fin, found;
        seen_int = 1'b0; seen_fin = 1'b0;
        do_reset(32'h0000_0020, 32'h0);
        int_rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (int_o !== 1'b0) seen_int = 1'b1;
            if (fin !== 32'h0) seen_fin = 1'b1;
        end
        int_rst = 1'b0;
        n_total++; if (seen_int) $display("FAIL mask_blocked: got int_o pulse, expected none"); else n_pass++;
        n_total++; if (seen_fin) $display("FAIL mask_rst_ignored: got fin pulse, expected none"); else n_pass++;
        mie = 32'h0000_0020;
        wait_int(32, found);
        n_total++; if (found !== 1'b1) $display("FAIL mask_enable_int: got %b expected 1", found); else n_pass++;
        n_total++; if (mcause !== 32'h8000_0005) $display("FAIL mask_mcause: got %h expected 80000005", mcause); else n_pass++;
    endtask

    task automatic test_fairness();
        logic found;
        logic [4:0] exp_idx;
        do_reset(32'h0008_0008, 32'hFFFF_FFFF);
        for (int s = 0; s < 6; s++) begin
            exp_idx = (s % 2 == 0) ? 5'd3 : 5'd19;
            wait_int(40, found);
            n_total++; if (found !== 1'b1) $display("FAIL fair_found_%0d: got %b expected 1", s, found); else n_pass++;
            n_total++;
            if (mcause !== {1'b1, 26'b0, exp_idx}) $display("FAIL fair_mcause_%0d: got %h expected %h", s, mcause, {1'b1, 26'b0, exp_idx});
            else n_pass++;
            tick();
            int_rst = 1'b1;
            tick();
            int_rst = 1'b0;
            n_total++;
            if (fin !== (32'h1 << exp_idx)) $display("FAIL fair_fin_%0d: got %h expected %h", s, fin, 32'h1 << exp_idx);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic found;
        do_reset(32'h0000_0018, 32'h0000_0018);
        wait_int(10, found);
        n_total++; if (mcause !== 32'h8000_0003) $display("FAIL b2b_first: got %h expected 80000003", mcause); else n_pass++;
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;
        n_total++; if (fin !== 32'h0000_0008) $display("FAIL b2b_fin: got %h expected 00000008", fin); else n_pass++;
        tick();
        n_total++; if (int_o !== 1'b0) $display("FAIL b2b_gap: int_o got %b expected 0", int_o); else n_pass++;
        tick();
        n_total++; if (int_o !== 1'b1) $display("FAIL b2b_second: int_o got %b expected 1", int_o); else n_pass++;
        n_total++; if (mcause !== 32'h8000_0004) $display("FAIL b2b_mcause: got %h expected 80000004", mcause); else n_pass++;
    endtask

    task automatic test_hold_in_serve();
        logic found;
        do_reset(32'h0008_0000, 32'h0008_0000);
        wait_int(40, found);
        tick();
        req = 32'h0;
        mie = 32'h0;
        repeat (4) tick();
        n_total++; if (mcause !== 32'h8000_0013) $display("FAIL hold_mcause: got %h expected 80000013", mcause); else n_pass++;
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;
        n_total++; if (fin !== 32'h0008_0000) $display("FAIL hold_fin: got %h expected 00080000", fin); else n_pass++;
    endtask

    task automatic test_reset_mid_service();
        logic found, seen;
        seen = 1'b0;
        do_reset(32'h0008_0000, 32'h0008_0000);
        wait_int(40, found);
        tick();
        #2;
        rst_n   = 1'b0;
        int_rst = 1'b1;
        #1;
        n_total++;
        if ({int_o, mcause, fin} !== 65'h0) $display("FAIL midrst_async: got int_o=%b mcause=%h fin=%h expected all 0", int_o, mcause, fin);
        else n_pass++;
        req = 32'h0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fin !== 32'h0 || int_o !== 1'b0) seen = 1'b1;
        end
        int_rst = 1'b0;
        n_total++; if (seen) $display("FAIL midrst_no_fin: got output pulse after release, expected none"); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; req = 32'h0; mie = 32'h0; int_rst = 1'b0;
        test_reset();
        test_basic_service();
        test_masking();
        test_fairness();
        test_back_to_back();
        test_hold_in_serve();
        test_reset_mid_service();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/miriscv_int_ctrl.md
# miriscv_int_ctrl

Interrupt controller for the miriscv core. It sits between the external `int_req_i` lines and the core's trap logic. It qualifies the 32 level-sensitive requests with the CSR `mie` mask and selects one using a rotating scan. It then raises a one-cycle interrupt to the core with the matching `mcause`. When the core signals completion, it returns a one-cycle, one-hot `int_fin_o` acknowledge to the requesting peripheral.

## Interface
- `INT_NUM`, 32: number of interrupt lines; a power of two, 2..32.
- `clk_i`  in  1  core clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `int_req_i`  in  INT_NUM  level requests from peripherals; synchronous to `clk_i`, no synchronizers inside.
- `mie_i`  in  INT_NUM  enable mask from the CSR file.
- `int_rst_i`  in  1  one-cycle pulse from the core on `mret`: current interrupt serviced.
- `int_o`  out  1  one-cycle pulse to the core: take interrupt trap.
- `mcause_o`  out  32  cause for the CSR file; stable from the `int_o` cycle until service ends.
- `int_fin_o`  out  INT_NUM  one-hot, one-cycle acknowledge to the serviced line.

## Operation
- State register has three states: SCAN, SERVE, FINISH. Scan counter `cnt` is `$clog2(INT_NUM)` bits.
- **SCAN**
  - `hit = int_req_i[cnt] & mie_i[cnt]`.
  - If `!hit`: `cnt <= cnt + 1`, wrapping from INT_NUM-1 to 0.
  - If `hit`: go to SERVE and hold `cnt`. Register `int_o <= 1` and `mcause_o <= {1'b1, 26'b0, cnt zero-extended to 5 bits}`.
- **SERVE**
  - `int_o` is low after its single cycle, and `cnt` is frozen.
  - Wait for `int_rst_i`. A dropped request or a cleared `mie` bit does not cancel service.
  - On `int_rst_i`: go to FINISH and register `int_fin_o <= 1 << cnt`.
- **FINISH** (one cycle)
  - `int_fin_o` is high this cycle only.
  - `cnt <= cnt + 1` (wrapping) to give round-robin fairness.
  - Next state is SCAN, and `mcause_o` clears to 0.
- `int_rst_i` in SCAN or FINISH is ignored.
- A peripheral must drop its request within one cycle of seeing `int_fin_o`. A request still high at the next scan of the same index is treated as a new interrupt.
- Only one interrupt is in flight at a time. Requests arriving during SERVE or FINISH wait for the scan.

## Timing
- Reset values: state=SCAN, `cnt`=0, `int_o`=0, `mcause_o`=0, `int_fin_o`=0.
- Asserting `rst_n_i` mid-SERVE or mid-FINISH aborts immediately. No `int_fin_o` is emitted and no `int_o` re-pulse occurs.
- Detection latency: between 0 and INT_NUM-1 cycles of scanning. `int_o` is high in the cycle after the edge on which `hit` is sampled.
- `int_rst_i` to `int_fin_o`: `int_fin_o` is high in the cycle after the edge that samples `int_rst_i`.
- The scan resumes one cycle later, starting at `cnt+1`.
- Minimum turnaround between two `int_o` pulses is 3 cycles: `int_o`, then `int_rst_i` sampled, then FINISH, then SCAN hit.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `miriscv_int_pkg` holds:
  - enum `int_state_e` with SCAN, SERVE, FINISH;
  - `MCAUSE_INT_BIT = 31`;
  - the default `INT_NUM`.
- Single flat module; no sub-module. The counter and FSM are small enough to stay inline.
- The core instantiates the block inside `miriscv_top`. `int_req_i`/`int_fin_o` are passed straight through to top-level ports, and `mie_i`/`mcause_o`/`int_rst_i` connect to the CSR unit.

## Test plan
- **Reset:** hold `rst_n_i`=0 with all requests high. Required: `int_o`=0, `mcause_o`=0, `int_fin_o`=0, and no pulse until release.
- **Basic service:**
  - Stimulus: `mie_i`=0x0008_0000, `int_req_i[19]`=1 from reset release.
  - Required: `int_o` pulses once 20 cycles after release, with `mcause_o`=0x8000_0013.
  - Then `int_rst_i` pulses. Required: `int_fin_o`=0x0008_0000 for exactly one cycle, then `mcause_o`=0.
- **Masking:** `int_req_i[5]`=1 with `mie_i`=0. Required: no `int_o` within 64 cycles. Then set `mie_i[5]`. Required: `int_o` within 32 cycles, with `mcause_o`=0x8000_0005.
- **Fairness and wrap:**
  - Stimulus: requests 3 and 19 held continuously; `int_rst_i` returned after each `int_o`.
  - Required: serviced order alternates 3, 19, 3, 19, …, with the scan wrapping past 31 to 0.
- **Hold in SERVE:** drop `int_req_i[19]` and clear `mie_i` during SERVE. Required: `mcause_o` stays at 0x8000_0013, and `int_fin_o[19]` still pulses on `int_rst_i`.
- **Reset mid-service:** assert `rst_n_i` while in SERVE. Required: all outputs go to 0 asynchronously, and no `int_fin_o` is produced after release.
